rgmii_rx_framer: RTL and testbench
==================================

Name: rgmii_rx_framer

Overview:
- Sits directly after the RGMII DDR capture stage, in the recovered RX clock domain.
- Consumes the per-clock byte, valid and error stream from that stage; supports gigabit (byte per clock) and 10/100 (nibble per clock) modes.
- Strips preamble/SFD, packs payload into OUT_BYTES-wide beats with keep/last/user, decodes RGMII in-band link status and keeps frame counters.

Parameters:
- OUT_BYTES, 1, output beat width in bytes; legal values 1, 2, 4.
- MAX_LEN, 1522, maximum payload bytes after SFD before truncation.
- CNT_W, 16, width of the frame counters.

Ports:
- clk  in  1  RX clock (buffered RGMII RX clock).
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from DDR capture; in 10/100 mode only [3:0] is used.
- rx_valid  in  1  RX_DV.
- rx_error  in  1  RX_ER (already decoded as ctl_rise XOR ctl_fall).
- nibble_mode  in  1  1 = 10/100 mode, 0 = gigabit mode; sampled only in IDLE.
- m_data  out  8*OUT_BYTES  payload beat; byte 0 in [7:0] is the earliest byte.
- m_keep  out  OUT_BYTES  valid byte lanes; contiguous from lane 0.
- m_valid  out  1  one-clock beat strobe; no backpressure.
- m_last  out  1  final beat of frame.
- m_user  out  1  frame error; meaningful only with m_last.
- link_up  out  1  in-band link status.
- link_speed  out  2  in-band speed: 00 = 10M, 01 = 100M, 10 = 1G.
- full_duplex  out  1  in-band duplex.
- frame_ok_cnt  out  CNT_W  good frames, saturating.
- frame_err_cnt  out  CNT_W  errored, truncated or dropped frames, saturating.

Behaviour:
- Reset:
  - All outputs go to 0.
  - State goes to WAIT_IDLE; the nibble assembler and beat buffer clear.
- Byte assembly:
  - Gigabit mode: one byte per clock while rx_valid = 1.
  - 10/100 mode: the first nibble is the low nibble and the second is the high nibble, giving one byte per two clocks.
  - An odd final nibble (dribble) is discarded with no error.
- States:
  - WAIT_IDLE: stay until rx_valid = 0, then go to IDLE. Never joins a frame mid-stream.
  - IDLE:
    - When rx_valid = 0 and rx_error = 0, register link_up = rx_data[0], link_speed = rx_data[2:1], full_duplex = rx_data[3] every clock.
    - On rx_valid = 1, latch nibble_mode and go to PREAMBLE.
  - PREAMBLE:
    - Assembled byte 0x55: stay.
    - 0xD5: go to PAYLOAD.
    - Any other byte, or rx_error = 1: go to DROP.
    - rx_valid = 0 before SFD: go to IDLE, count as error, emit nothing.
  - PAYLOAD:
    - Pack bytes into lanes 0..OUT_BYTES-1.
    - rx_error = 1 on any clock sets a sticky error flag.
  - DROP: no output; on rx_valid = 0, increment frame_err_cnt and go to IDLE.
- Beat release (PAYLOAD):
  - A full word is held, not emitted, until the next byte arrives or rx_valid falls, so that m_last is always on a data beat.
  - A full word is emitted one clock after the first byte of the following word is assembled, with m_keep all ones, m_last = 0.
  - On rx_valid falling, the held or partial word is emitted the next clock with m_last = 1, m_keep = filled lanes, m_user = sticky error.
  - Gigabit, OUT_BYTES = 1: byte k appears on m_data two clocks after its input clock.
  - If rx_valid falls right after SFD (zero payload), emit nothing and count as error.
- Truncation:
  - When the byte count reaches MAX_LEN, emit the current word with m_last = 1, m_user = 1, then go to DROP.
  - If rx_valid falls on the same clock, the normal end path wins only when no byte beyond MAX_LEN arrived.
- Counters:
  - On each emitted m_last, increment frame_ok_cnt if m_user = 0, else frame_err_cnt.
  - Both counters saturate at all ones.
  - An error frame that also goes through DROP is counted exactly once.
- nibble_mode changes while not in IDLE take effect at the next frame.

Test Plan:
- Gigabit, OUT_BYTES = 1: 7×0x55, 0xD5, payload 0x01..0x40 (64 B) -> 64 beats, data 0x01..0x40 in order, m_last on 0x40, m_user = 0, frame_ok_cnt = 1.
- OUT_BYTES = 4, gigabit, 61-byte payload -> 16 beats; last beat m_keep = 0001; all earlier beats m_keep = 1111.
- nibble_mode = 1: nibbles 5,5,…,5,D, then 1,0,2,0 -> bytes 0x01, 0x02; extra trailing nibble 0x7 discarded, m_user = 0.
- rx_error pulse mid-payload -> final beat m_user = 1, frame_err_cnt = 1. Preamble byte 0x54 -> no beats, frame_err_cnt increments on rx_valid fall.
- MAX_LEN = 64, 100-byte payload -> beat 64 has m_last = 1, m_user = 1; remaining 36 bytes dropped; only one error count.
- Idle rx_data = 0x0D with rx_valid = 0, rx_error = 0 -> link_up = 1, link_speed = 10, full_duplex = 1. Reset asserted mid-frame -> outputs 0, no beats until rx_valid low then a new preamble.

Source files
------------

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD, packs payload bytes into OUT_BYTES-wide
// beats with keep/last/user, samples in-band link status and keeps frame counters.
//
// state     | meaning
// WAIT_IDLE | after reset; wait for rx_valid low so a frame is never joined mid-stream
// IDLE      | inter-frame gap; in-band link status sampled here
// PREAMBLE  | consuming 0x55 bytes until the 0xD5 SFD
// PAYLOAD   | packing payload bytes into beats
// DROP      | discarding the rest of a bad or truncated frame
module rgmii_rx_framer #(
    parameter int OUT_BYTES = 1,
    parameter int MAX_LEN   = 1522,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   rx_error,
    input  logic                   nibble_mode,
    output logic [8*OUT_BYTES-1:0] m_data,
    output logic [OUT_BYTES-1:0]   m_keep,
    output logic                   m_valid,
    output logic                   m_last,
    output logic                   m_user,
    output logic                   link_up,
    output logic [1:0]             link_speed,
    output logic                   full_duplex,
    output logic [CNT_W-1:0]       frame_ok_cnt,
    output logic [CNT_W-1:0]       frame_err_cnt
);

    localparam int FILL_W = $clog2(OUT_BYTES + 1);
    localparam int REM_W  = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_DROP
    } state_t;

    state_t                 state;
    logic                   nib_mode_q;
    logic                   nib_phase;
    logic [3:0]             nib_lo;
    logic                   asm_nib;
    logic                   byte_vld;
    logic [7:0]             asm_byte;
    logic [8*OUT_BYTES-1:0] word_q;
    logic [FILL_W-1:0]      fill_q;
    logic [OUT_BYTES-1:0]   fill_mask;
    logic [REM_W-1:0]       remain_q;
    logic                   err_sticky;
    logic                   drop_pending;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // The first nibble of a frame arrives in IDLE, before nib_mode_q is loaded.
    always_comb begin
        asm_nib  = (state == S_IDLE) ? nibble_mode : nib_mode_q;
        byte_vld = 1'b0;
        asm_byte = rx_data;
        if (rx_valid) begin
            if (!asm_nib) begin
                byte_vld = 1'b1;
            end else if (nib_phase) begin
                byte_vld = 1'b1;
                asm_byte = {rx_data[3:0], nib_lo};
            end
        end
    end

    always_comb begin
        fill_mask = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            fill_mask[i] = (FILL_W'(i) < fill_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_WAIT_IDLE;
            nib_mode_q    <= 1'b0;
            nib_phase     <= 1'b0;
            nib_lo        <= '0;
            word_q        <= '0;
            fill_q        <= '0;
            remain_q      <= '0;
            err_sticky    <= 1'b0;
            drop_pending  <= 1'b0;
            m_data        <= '0;
            m_keep        <= '0;
            m_valid       <= 1'b0;
            m_last        <= 1'b0;
            m_user        <= 1'b0;
            link_up       <= 1'b0;
            link_speed    <= '0;
            full_duplex   <= 1'b0;
            frame_ok_cnt  <= '0;
            frame_err_cnt <= '0;
        end else begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_user  <= 1'b0;

            // A dangling low nibble when rx_valid drops is simply forgotten.
            if (rx_valid && asm_nib && !nib_phase) begin
                nib_lo    <= rx_data[3:0];
                nib_phase <= 1'b1;
            end else begin
                nib_phase <= 1'b0;
            end

            case (state)
                S_WAIT_IDLE: begin
                    if (!rx_valid) state <= S_IDLE;
                end

                S_IDLE: begin
                    if (rx_valid) begin
                        nib_mode_q <= nibble_mode;
                        state      <= S_PREAMBLE;
                    end else if (!rx_error) begin
                        link_up     <= rx_data[0];
                        link_speed  <= rx_data[2:1];
                        full_duplex <= rx_data[3];
                    end
                end

                S_PREAMBLE: begin
                    if (!rx_valid) begin
                        frame_err_cnt <= sat_inc(frame_err_cnt);
                        state         <= S_IDLE;
                    end else if (rx_error) begin
                        drop_pending <= 1'b1;
                        state        <= S_DROP;
                    end else if (byte_vld) begin
                        if (asm_byte == 8'hD5) begin
                            fill_q     <= '0;
                            remain_q   <= REM_W'(MAX_LEN);
                            err_sticky <= 1'b0;
                            state      <= S_PAYLOAD;
                        end else if (asm_byte != 8'h55) begin
                            drop_pending <= 1'b1;
                            state        <= S_DROP;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (!rx_valid) begin
                        state <= S_IDLE;
                        if (fill_q == '0) begin
                            frame_err_cnt <= sat_inc(frame_err_cnt);
                        end else begin
                            m_valid <= 1'b1;
                            m_last  <= 1'b1;
                            m_data  <= word_q;
                            m_keep  <= fill_mask;
                            m_user  <= err_sticky;
                            if (err_sticky) frame_err_cnt <= sat_inc(frame_err_cnt);
                            else            frame_ok_cnt  <= sat_inc(frame_ok_cnt);
                        end
                    end else begin
                        if (rx_error) err_sticky <= 1'b1;
                        if (byte_vld) begin
                            if (remain_q == '0) begin
                                // Byte MAX_LEN+1: close the frame as errored, already counted.
                                m_valid       <= 1'b1;
                                m_last        <= 1'b1;
                                m_user        <= 1'b1;
                                m_data        <= word_q;
                                m_keep        <= fill_mask;
                                frame_err_cnt <= sat_inc(frame_err_cnt);
                                drop_pending  <= 1'b0;
                                state         <= S_DROP;
                            end else begin
                                remain_q <= remain_q - 1'b1;
                                if (fill_q == FILL_W'(OUT_BYTES)) begin
                                    m_valid     <= 1'b1;
                                    m_data      <= word_q;
                                    m_keep      <= '1;
                                    word_q[7:0] <= asm_byte;
                                    fill_q      <= FILL_W'(1);
                                end else begin
                                    for (int i = 0; i < OUT_BYTES; i++) begin
                                        if (fill_q == FILL_W'(i)) word_q[8*i +: 8] <= asm_byte;
                                    end
                                    fill_q <= fill_q + 1'b1;
                                end
                            end
                        end
                    end
                end

                S_DROP: begin
                    if (!rx_valid) begin
                        if (drop_pending) frame_err_cnt <= sat_inc(frame_err_cnt);
                        drop_pending <= 1'b0;
                        state        <= S_IDLE;
                    end
                end

                default: state <= S_WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Directed bench for rgmii_rx_framer: a 1-byte instance (MAX_LEN 64) and a 4-byte
// instance share the RX stream; beats from both are captured for per-test checks.
module tb_rgmii_rx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic        nibble_mode;
    logic [7:0]  idle_byte = 8'h00;

    logic [7:0]  d1_data;
    logic [0:0]  d1_keep;
    logic        d1_valid, d1_last, d1_user, d1_link, d1_fd;
    logic [1:0]  d1_speed;
    logic [15:0] d1_ok, d1_err;

    logic [31:0] d4_data;
    logic [3:0]  d4_keep;
    logic        d4_valid, d4_last, d4_user, d4_link, d4_fd;
    logic [1:0]  d4_speed;
    logic [15:0] d4_ok, d4_err;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    rgmii_rx_framer #(.OUT_BYTES(1), .MAX_LEN(64), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
        .nibble_mode(nibble_mode), .m_data(d1_data), .m_keep(d1_keep), .m_valid(d1_valid),
        .m_last(d1_last), .m_user(d1_user), .link_up(d1_link), .link_speed(d1_speed),
        .full_duplex(d1_fd), .frame_ok_cnt(d1_ok), .frame_err_cnt(d1_err)
    );

    rgmii_rx_framer #(.OUT_BYTES(4), .MAX_LEN(1522), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
        .nibble_mode(nibble_mode), .m_data(d4_data), .m_keep(d4_keep), .m_valid(d4_valid),
        .m_last(d4_last), .m_user(d4_user), .link_up(d4_link), .link_speed(d4_speed),
        .full_duplex(d4_fd), .frame_ok_cnt(d4_ok), .frame_err_cnt(d4_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  c1_data [0:255];
    logic        c1_last [0:255];
    logic        c1_user [0:255];
    int          c1_cyc  [0:255];
    int          n1 = 0;
    logic [31:0] c4_data [0:127];
    logic [3:0]  c4_keep [0:127];
    logic        c4_last [0:127];
    int          n4 = 0;

    always @(negedge clk) begin
        if (d1_valid) begin
            if (n1 < 256) begin
                c1_data[n1] = d1_data;
                c1_last[n1] = d1_last;
                c1_user[n1] = d1_user;
                c1_cyc[n1]  = cyc;
            end
            n1 = n1 + 1;
        end
        if (d4_valid) begin
            if (n4 < 128) begin
                c4_data[n4] = d4_data;
                c4_keep[n4] = d4_keep;
                c4_last[n4] = d4_last;
            end
            n4 = n4 + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic e);
        rx_data  = b;
        rx_valid = v;
        rx_error = e;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(b, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(idle_byte, 1'b0, 1'b0);
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    task automatic test_reset();
        checks++; if (d1_valid !== 1'b0 || d1_last !== 1'b0 || d1_user !== 1'b0)
            $display("FAIL reset_strobes: got v=%b l=%b u=%b expected 0 0 0", d1_valid, d1_last, d1_user);
        else passed++;
        checks++; if (d1_data !== 8'h00 || d4_data !== 32'h0 || d4_keep !== 4'h0)
            $display("FAIL reset_data: got %h/%h/%h expected zeros", d1_data, d4_data, d4_keep);
        else passed++;
        checks++; if ({d1_link, d1_speed, d1_fd} !== 4'b0000)
            $display("FAIL reset_link: got %b expected 0000", {d1_link, d1_speed, d1_fd});
        else passed++;
        checks++; if (d1_ok !== 16'd0 || d1_err !== 16'd0 || d4_ok !== 16'd0 || d4_err !== 16'd0)
            $display("FAIL reset_counters: got %0d %0d %0d %0d expected 0", d1_ok, d1_err, d4_ok, d4_err);
        else passed++;
    endtask

    task automatic test_link_status();
        idle_byte = 8'h0D;
        idle(3);
        checks++; if ({d1_link, d1_speed, d1_fd} !== 4'b1101)
            $display("FAIL link_0d: got %b expected 1101", {d1_link, d1_speed, d1_fd});
        else passed++;
        drive(8'hF0, 1'b0, 1'b1);
        drive(8'hF0, 1'b0, 1'b1);
        checks++; if ({d4_link, d4_speed, d4_fd} !== 4'b1101)
            $display("FAIL link_hold_on_error: got %b expected 1101", {d4_link, d4_speed, d4_fd});
        else passed++;
        idle_byte = 8'h02;
        idle(3);
        checks++; if ({d1_link, d1_speed, d1_fd} !== 4'b0010)
            $display("FAIL link_02: got %b expected 0010", {d1_link, d1_speed, d1_fd});
        else passed++;
        idle_byte = 8'h0D;
        idle(3);
    endtask

    task automatic test_gig_64();
        int b1, b4, t0, bad, lasts;
        b1 = n1; b4 = n4; bad = 0; lasts = 0;
        send_preamble();
        t0 = cyc;
        for (int k = 1; k <= 64; k++) send_byte(8'(k));
        idle(4);
        checks++; if (n1 - b1 !== 64) $display("FAIL gig64_beats: got %0d expected 64", n1 - b1);
        else passed++;
        for (int k = 0; k < 64; k++) begin
            if (c1_data[b1+k] !== 8'(k + 1)) bad++;
            if (c1_last[b1+k]) lasts++;
        end
        checks++; if (bad !== 0 || lasts !== 1 || c1_last[b1+63] !== 1'b1)
            $display("FAIL gig64_order: got bad=%0d lasts=%0d last63=%b expected 0 1 1", bad, lasts, c1_last[b1+63]);
        else passed++;
        checks++; if (c1_user[b1+63] !== 1'b0) $display("FAIL gig64_user: got %b expected 0", c1_user[b1+63]);
        else passed++;
        checks++; if (c1_cyc[b1] !== t0 + 2) $display("FAIL gig64_latency: got %0d expected %0d", c1_cyc[b1], t0 + 2);
        else passed++;
        checks++; if (d1_ok !== 16'd1 || d1_err !== 16'd0)
            $display("FAIL gig64_counters: got ok=%0d err=%0d expected 1 0", d1_ok, d1_err);
        else passed++;
        checks++; if (n4 - b4 !== 16 || c4_keep[b4+15] !== 4'b1111 || c4_last[b4+15] !== 1'b1)
            $display("FAIL gig64_wide: got beats=%0d keep=%b last=%b expected 16 1111 1", n4 - b4, c4_keep[b4+15], c4_last[b4+15]);
        else passed++;
    endtask

    task automatic test_keep4();
        int b4, bad;
        b4 = n4; bad = 0;
        send_preamble();
        for (int k = 1; k <= 61; k++) send_byte(8'(k));
        idle(4);
        checks++; if (n4 - b4 !== 16) $display("FAIL keep4_beats: got %0d expected 16", n4 - b4);
        else passed++;
        for (int k = 0; k < 15; k++) if (c4_keep[b4+k] !== 4'b1111 || c4_last[b4+k] !== 1'b0) bad++;
        checks++; if (bad !== 0) $display("FAIL keep4_full_beats: got %0d bad beats expected 0", bad);
        else passed++;
        checks++; if (c4_keep[b4+15] !== 4'b0001 || c4_last[b4+15] !== 1'b1 || c4_data[b4+15][7:0] !== 8'h3D)
            $display("FAIL keep4_last_beat: got keep=%b last=%b d=%h expected 0001 1 3d", c4_keep[b4+15], c4_last[b4+15], c4_data[b4+15][7:0]);
        else passed++;
        checks++; if (c4_data[b4] !== 32'h04030201) $display("FAIL keep4_first_data: got %h expected 04030201", c4_data[b4]);
        else passed++;
        checks++; if (d4_ok !== 16'd2 || d1_ok !== 16'd2)
            $display("FAIL keep4_counters: got %0d/%0d expected 2/2", d4_ok, d1_ok);
        else passed++;
    endtask

    task automatic test_nibble();
        int b1, b4;
        logic [3:0] nibs [0:4];
        nibs[0] = 4'h1; nibs[1] = 4'h0; nibs[2] = 4'h2; nibs[3] = 4'h0; nibs[4] = 4'h7;
        nibble_mode = 1'b1;
        idle(2);
        b1 = n1; b4 = n4;
        for (int i = 0; i < 15; i++) send_byte({4'hA, 4'h5});
        send_byte({4'hA, 4'hD});
        for (int i = 0; i < 5; i++) send_byte({4'hA, nibs[i]});
        idle(4);
        nibble_mode = 1'b0;
        idle(2);
        checks++; if (n1 - b1 !== 2 || c1_data[b1] !== 8'h01 || c1_data[b1+1] !== 8'h02)
            $display("FAIL nibble_bytes: got n=%0d %h %h expected 2 01 02", n1 - b1, c1_data[b1], c1_data[b1+1]);
        else passed++;
        checks++; if (c1_last[b1] !== 1'b0 || c1_last[b1+1] !== 1'b1 || c1_user[b1+1] !== 1'b0)
            $display("FAIL nibble_last: got %b %b user %b expected 0 1 0", c1_last[b1], c1_last[b1+1], c1_user[b1+1]);
        else passed++;
        checks++; if (n4 - b4 !== 1 || c4_keep[b4] !== 4'b0011 || c4_data[b4][15:0] !== 16'h0201)
            $display("FAIL nibble_wide: got n=%0d keep=%b d=%h expected 1 0011 0201", n4 - b4, c4_keep[b4], c4_data[b4][15:0]);
        else passed++;
        checks++; if (d1_ok !== 16'd3 || d1_err !== 16'd0) $display("FAIL nibble_counters: got %0d %0d expected 3 0", d1_ok, d1_err);
        else passed++;
    endtask

    task automatic test_error();
        int b1;
        b1 = n1;
        send_preamble();
        for (int k = 1; k <= 10; k++) drive(8'(k), 1'b1, (k == 5));
        idle(4);
        checks++; if (n1 - b1 !== 10 || c1_last[b1+9] !== 1'b1 || c1_user[b1+9] !== 1'b1)
            $display("FAIL error_user: got n=%0d last=%b user=%b expected 10 1 1", n1 - b1, c1_last[b1+9], c1_user[b1+9]);
        else passed++;
        checks++; if (d1_err !== 16'd1 || d1_ok !== 16'd3) $display("FAIL error_counters: got err=%0d ok=%0d expected 1 3", d1_err, d1_ok);
        else passed++;
    endtask

    task automatic test_drop_cases();
        int b1;
        logic [7:0] bad_pre [0:5];
        bad_pre[0] = 8'h55; bad_pre[1] = 8'h55; bad_pre[2] = 8'h55;
        bad_pre[3] = 8'h54; bad_pre[4] = 8'h55; bad_pre[5] = 8'hD5;
        b1 = n1;
        for (int i = 0; i < 6; i++) send_byte(bad_pre[i]);
        for (int k = 1; k <= 8; k++) send_byte(8'(k));
        idle(4);
        checks++; if (n1 !== b1 || d1_err !== 16'd2) $display("FAIL bad_preamble: got beats=%0d err=%0d expected 0 2", n1 - b1, d1_err);
        else passed++;
        for (int i = 0; i < 4; i++) send_byte(8'h55);
        idle(4);
        checks++; if (n1 !== b1 || d1_err !== 16'd3) $display("FAIL preamble_abort: got beats=%0d err=%0d expected 0 3", n1 - b1, d1_err);
        else passed++;
        send_preamble();
        idle(4);
        checks++; if (n1 !== b1 || d1_err !== 16'd4 || d4_err !== 16'd4)
            $display("FAIL zero_payload: got beats=%0d err=%0d/%0d expected 0 4/4", n1 - b1, d1_err, d4_err);
        else passed++;
    endtask

    task automatic test_trunc();
        int b1, lasts;
        b1 = n1; lasts = 0;
        send_preamble();
        for (int k = 1; k <= 100; k++) send_byte(8'(k));
        idle(4);
        for (int k = 0; k < n1 - b1; k++) if (c1_last[b1+k]) lasts++;
        checks++; if (n1 - b1 !== 64 || lasts !== 1)
            $display("FAIL trunc_beats: got n=%0d lasts=%0d expected 64 1", n1 - b1, lasts);
        else passed++;
        checks++; if (c1_last[b1+63] !== 1'b1 || c1_user[b1+63] !== 1'b1 || c1_data[b1+63] !== 8'h40)
            $display("FAIL trunc_last_beat: got last=%b user=%b d=%h expected 1 1 40", c1_last[b1+63], c1_user[b1+63], c1_data[b1+63]);
        else passed++;
        checks++; if (d1_err !== 16'd5 || d1_ok !== 16'd3) $display("FAIL trunc_counters: got err=%0d ok=%0d expected 5 3", d1_err, d1_ok);
        else passed++;
        checks++; if (d4_ok !== 16'd4) $display("FAIL trunc_wide_ok: got %0d expected 4", d4_ok);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int b1;
        send_preamble();
        for (int k = 1; k <= 20; k++) send_byte(8'(k));
        rst = 1'b1;
        send_byte(8'd21);
        send_byte(8'd22);
        checks++; if (d1_valid !== 1'b0 || d1_ok !== 16'd0 || d1_err !== 16'd0 || d1_link !== 1'b0)
            $display("FAIL reset_mid_outputs: got v=%b ok=%0d err=%0d link=%b expected 0 0 0 0", d1_valid, d1_ok, d1_err, d1_link);
        else passed++;
        rst = 1'b0;
        b1 = n1;
        for (int i = 0; i < 5; i++) send_byte(8'h55);
        send_byte(8'hD5);
        for (int k = 1; k <= 10; k++) send_byte(8'(k));
        checks++; if (n1 !== b1) $display("FAIL reset_mid_no_join: got %0d beats expected 0", n1 - b1);
        else passed++;
        idle(3);
        send_preamble();
        for (int k = 1; k <= 3; k++) send_byte(8'(k));
        idle(4);
        checks++; if (n1 - b1 !== 3 || c1_data[b1] !== 8'h01 || c1_data[b1+2] !== 8'h03 || c1_last[b1+2] !== 1'b1)
            $display("FAIL reset_mid_new_frame: got n=%0d %h %h last=%b expected 3 01 03 1", n1 - b1, c1_data[b1], c1_data[b1+2], c1_last[b1+2]);
        else passed++;
        checks++; if (d1_ok !== 16'd1 || d1_err !== 16'd0) $display("FAIL reset_mid_counters: got %0d %0d expected 1 0", d1_ok, d1_err);
        else passed++;
    endtask

    initial begin
        rst         = 1'b1;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        rx_error    = 1'b0;
        nibble_mode = 1'b0;
        tick(); tick(); tick();
        test_reset();
        rst = 1'b0;
        test_link_status();
        test_gig_64();
        test_keep4();
        test_nibble();
        test_error();
        test_drop_cases();
        test_trunc();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
